num_toupper: RTL and testbench
==============================

Name: num_toupper

Overview:
- Registered ASCII lower-to-upper case converter for one 8-bit character per clock.
- Input byte arrives on eight single-bit ports A..H, with A as the MSB (bit 7) and H as the LSB (bit 0).
- Output byte leaves on W1..W8, with W1 as the MSB and W8 as the LSB.
- Sits in the character-processing path; it also reports whether a conversion occurred and keeps a running count of conversions.

Parameters:
- CNT_W, 16, width of the saturating conversion counter (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input byte on A..H is valid this cycle.
- A  input  1  input bit 7 (MSB).
- B  input  1  input bit 6.
- C  input  1  input bit 5 (the case bit).
- D  input  1  input bit 4.
- E  input  1  input bit 3.
- F  input  1  input bit 2.
- G  input  1  input bit 1.
- H  input  1  input bit 0 (LSB).
- W1..W8  output  1 each  output byte, W1 = bit 7 through W8 = bit 0; registered.
- out_valid  output  1  W1..W8 hold a result produced from a valid input.
- changed  output  1  the last accepted byte was lowercase and was converted.
- conv_count  output  CNT_W  number of conversions since reset; saturates.

Behaviour:
- Let X = {A,B,C,D,E,F,G,H}.
- Conversion rule is purely combinational ahead of the output registers:
  - If 0x61 <= X <= 0x7A ('a'..'z'), result = X - 0x20. This is equivalent to clearing bit 5 (C) and leaving all other bits unchanged.
  - Every other value passes through unchanged. This includes 0x00-0x60, 0x7B-0x7F and 0x80-0xFF.
  - The range bounds are exact: 0x60 '`' and 0x7B '{' are not converted.
- Latency is one cycle. If in_valid = 1 at edge N, then after edge N:
  - W1..W8 = result.
  - out_valid = 1.
  - changed = (X was in the lowercase range).
- If in_valid = 0 at an edge:
  - out_valid becomes 0.
  - W1..W8 and changed hold their previous values.
- There is no backpressure: one byte can be accepted every cycle and back-to-back inputs are allowed.
- conv_count increments by 1 on each edge where in_valid = 1 and X is in the lowercase range.
- At all-ones, conv_count holds its value; it never wraps.
- Reset (rst = 1 at a rising edge) has priority over everything else and sets:
  - W1..W8 = 0.
  - out_valid = 0.
  - changed = 0.
  - conv_count = 0.
- Reset asserted mid-stream discards the byte presented in that cycle. The first byte accepted after reset is the one presented on the first edge with rst = 0.
- Outputs are driven only from flops, never combinationally from the inputs.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with arbitrary inputs -> W = 0x00, out_valid = 0, changed = 0, conv_count = 0.
- Lowercase letters:
  - 0x61 'a' -> W = 0x41, changed = 1.
  - 0x7A 'z' -> W = 0x5A, changed = 1.
  - 0x6D 'm' -> W = 0x4D, changed = 1.
  - Each result appears one cycle later with out_valid = 1; conv_count = 3 after the three bytes.
- Passthrough:
  - 0x28 -> 0x28; 0x48 'H' -> 0x48; 0x41 -> 0x41; 0x47 -> 0x47.
  - 0x60 -> 0x60; 0x7B -> 0x7B; 0xB7 -> 0xB7; 0xEB -> 0xEB; 0xFF -> 0xFF.
  - All of these give changed = 0 and leave conv_count unchanged.
- Back-to-back stream: 0x68, 0x69, 0x21 on consecutive cycles with in_valid = 1 -> outputs 0x48, 0x49, 0x21 on the next three cycles, with changed = 1, 1, 0.
- Valid gating: present 0x61 with in_valid = 0 -> out_valid = 0, W holds its previous value, conv_count unchanged.
- Saturation and mid-stream reset:
  - With CNT_W = 2, feed 5 lowercase bytes -> conv_count = 3.
  - Then assert rst for one cycle while feeding 0x61 -> all outputs 0.

Source files
------------

// File: rtl/num_toupper.sv
// num_toupper: registered ASCII lower-to-upper case converter, one byte per clock.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active-high
//   in_valid   - input byte on A..H is valid this cycle
//   A..H       - input byte, A = bit 7 (MSB) .. H = bit 0 (LSB)
//   W1..W8     - registered output byte, W1 = bit 7 .. W8 = bit 0
//   out_valid  - W1..W8 hold a result produced from a valid input
//   changed    - last accepted byte was lowercase and was converted
//   conv_count - saturating count of conversions since reset (CNT_W bits)
module num_toupper #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             E,
    input  logic             F,
    input  logic             G,
    input  logic             H,
    output logic             W1,
    output logic             W2,
    output logic             W3,
    output logic             W4,
    output logic             W5,
    output logic             W6,
    output logic             W7,
    output logic             W8,
    output logic             out_valid,
    output logic             changed,
    output logic [CNT_W-1:0] conv_count
);

    function automatic logic is_lower(input logic [7:0] x);
        return (x >= 8'h61) && (x <= 8'h7A);
    endfunction

    // Inside 'a'..'z' the case bit is always set, so clearing it equals x - 0x20.
    function automatic logic [7:0] to_upper(input logic [7:0] x);
        return is_lower(x) ? (x & 8'hDF) : x;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Stage p0: input byte assembly and combinational classification
    logic [7:0] x_p0;
    logic       lower_p0;

    assign x_p0     = {A, B, C, D, E, F, G, H};
    assign lower_p0 = is_lower(x_p0);

    // Stage p1: output registers
    logic [7:0]       w_p1;
    logic             vld_p1;
    logic             chg_p1;
    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_p1   <= 8'h00;
            vld_p1 <= 1'b0;
            chg_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                w_p1   <= to_upper(x_p0);
                chg_p1 <= lower_p0;
                if (lower_p0)
                    cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign {W1, W2, W3, W4, W5, W6, W7, W8} = w_p1;
    assign out_valid  = vld_p1;
    assign changed    = chg_p1;
    assign conv_count = cnt_p1;

endmodule

// File: tb/tb_num_toupper.sv
// tb_num_toupper: drives directed and random bytes into two instances
// (CNT_W = 16 and CNT_W = 2) sharing the same inputs, and compares every
// output against a behavioural model after each clock edge.
module tb_num_toupper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] x_in = 8'h00;

    logic [7:0]  w16, w2;
    logic        ov16, ov2, ch16, ch2;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] m_w;
    logic       m_ov, m_ch;
    int         m_cnt16, m_cnt2;

    always #5 clk = ~clk;

    num_toupper #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(x_in[7]), .B(x_in[6]), .C(x_in[5]), .D(x_in[4]),
        .E(x_in[3]), .F(x_in[2]), .G(x_in[1]), .H(x_in[0]),
        .W1(w16[7]), .W2(w16[6]), .W3(w16[5]), .W4(w16[4]),
        .W5(w16[3]), .W6(w16[2]), .W7(w16[1]), .W8(w16[0]),
        .out_valid(ov16), .changed(ch16), .conv_count(cnt16)
    );

    num_toupper #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(x_in[7]), .B(x_in[6]), .C(x_in[5]), .D(x_in[4]),
        .E(x_in[3]), .F(x_in[2]), .G(x_in[1]), .H(x_in[0]),
        .W1(w2[7]), .W2(w2[6]), .W3(w2[5]), .W4(w2[4]),
        .W5(w2[3]), .W6(w2[2]), .W7(w2[1]), .W8(w2[0]),
        .out_valid(ov2), .changed(ch2), .conv_count(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Model written from the behavioural rules: range test and subtraction.
    task automatic model_edge(input logic r, input logic v, input logic [7:0] x);
        int  xv;
        bit  low;
        xv  = int'(x);
        low = (xv >= 97) && (xv <= 122);
        if (r) begin
            m_w = 8'h00; m_ov = 1'b0; m_ch = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
        end else begin
            m_ov = v;
            if (v) begin
                m_w  = low ? 8'(xv - 32) : x;
                m_ch = low;
                if (low && m_cnt16 < 65535) m_cnt16++;
                if (low && m_cnt2 < 3)      m_cnt2++;
            end
        end
    endtask

    // Present one byte for one clock, then compare both instances.
    task automatic step(input logic r, input logic v, input logic [7:0] x);
        @(negedge clk);
        rst = r; in_valid = v; x_in = x;
        @(posedge clk);
        model_edge(r, v, x);
        #1;
        check("w16",   32'(w16),   32'(m_w));
        check("ov16",  32'(ov16),  32'(m_ov));
        check("ch16",  32'(ch16),  32'(m_ch));
        check("cnt16", 32'(cnt16), 32'(m_cnt16));
        check("w2",    32'(w2),    32'(m_w));
        check("ov2",   32'(ov2),   32'(m_ov));
        check("ch2",   32'(ch2),   32'(m_ch));
        check("cnt2",  32'(cnt2),  32'(m_cnt2));
    endtask

    logic [7:0] pass_list [9] = '{8'h28, 8'h48, 8'h41, 8'h47, 8'h60, 8'h7B, 8'hB7, 8'hEB, 8'hFF};

    initial begin
        m_w = 8'h00; m_ov = 1'b0; m_ch = 1'b0; m_cnt16 = 0; m_cnt2 = 0;

        // Reset for two cycles with arbitrary inputs
        step(1'b1, 1'b1, 8'h61);
        step(1'b1, 1'b1, 8'h7A);
        check("rst_w", 32'(w16), 32'h00);
        check("rst_ov", 32'(ov16), 32'd0);
        check("rst_cnt", 32'(cnt16), 32'd0);

        // Lowercase letters
        step(1'b0, 1'b1, 8'h61);
        check("a_w", 32'(w16), 32'h41);
        check("a_ch", 32'(ch16), 32'd1);
        step(1'b0, 1'b1, 8'h7A);
        check("z_w", 32'(w16), 32'h5A);
        step(1'b0, 1'b1, 8'h6D);
        check("m_w", 32'(w16), 32'h4D);
        check("cnt_3", 32'(cnt16), 32'd3);

        // Passthrough values, including both range edges
        foreach (pass_list[i]) begin
            step(1'b0, 1'b1, pass_list[i]);
            check("pass_w", 32'(w16), 32'(pass_list[i]));
            check("pass_ch", 32'(ch16), 32'd0);
        end
        check("pass_cnt", 32'(cnt16), 32'd3);

        // Back-to-back stream
        step(1'b0, 1'b1, 8'h68);
        check("s0_w", 32'(w16), 32'h48);
        step(1'b0, 1'b1, 8'h69);
        check("s1_w", 32'(w16), 32'h49);
        step(1'b0, 1'b1, 8'h21);
        check("s2_w", 32'(w16), 32'h21);
        check("s2_ch", 32'(ch16), 32'd0);

        // Five conversions so far: narrow counter saturated
        check("sat_cnt2", 32'(cnt2), 32'd3);
        check("cnt16_5", 32'(cnt16), 32'd5);

        // Valid gating
        step(1'b0, 1'b0, 8'h61);
        check("gate_ov", 32'(ov16), 32'd0);
        check("gate_w", 32'(w16), 32'h21);
        check("gate_cnt", 32'(cnt16), 32'd5);

        // Mid-stream reset discards the presented byte
        step(1'b1, 1'b1, 8'h61);
        check("mrst_w", 32'(w16), 32'h00);
        check("mrst_cnt2", 32'(cnt2), 32'd0);
        step(1'b0, 1'b1, 8'h62);
        check("post_rst_w", 32'(w16), 32'h42);

        // Random traffic with occasional resets and idle cycles
        for (int i = 0; i < 400; i++) begin
            logic [7:0] rx;
            rx = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h5E, 8'h7D)) : 8'($urandom);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rx);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
